sprite_pixel_server: RTL and testbench

Memory-side responder for the player animation sprite path. Each cycle it accepts a sprite pixel request (valid + 21-bit sprite address), fetches the packed 16-bit ROM word, selects the 4-bit palette index, and returns a registered 24-bit RGB pixel with an opaque flag at a fixed latency. It sits between the animation address generators and the sprite ROM/SRAM port, and feeds the colour mapper. It suppresses redundant reads with a one-word hit register and keeps saturating read/hit statistics.

---
 rtl/sprite_pkg.sv | 25 ++
 rtl/sprite_palette_lut.sv | 40 ++++
 rtl/sprite_pixel_server.sv | 121 ++++++++++++
 tb/tb_sprite_pixel_server.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared widths, palette table and pipeline tag type for the sprite pixel server.
package sprite_pkg;

    localparam int SPRITE_ADDR_W = 21;
    localparam int WORD_W        = 16;
    localparam int IDX_W         = 4;
    localparam int RGB_W         = 24;
    localparam int WADDR_W       = SPRITE_ADDR_W - 2;

    // Entry 0 is never shown: index 0 is the transparent colour.
    localparam logic [RGB_W-1:0] PALETTE [16] = '{
        24'h000000, 24'hFF0000, 24'h00FF00, 24'h0000FF,
        24'hFFFF00, 24'hFF00FF, 24'h00FFFF, 24'hFFFFFF,
        24'h800000, 24'h008000, 24'h000080, 24'h808000,
        24'h800080, 24'h008080, 24'hC0C0C0, 24'h808080
    };

    typedef struct packed {
        logic       valid;
        logic       hit;
        logic       in_range;
        logic [1:0] nibble;
    } pipe_tag_t;

endpackage

// File: rtl/sprite_palette_lut.sv
// Output stage: registered palette lookup; transparent or idle slots drive black.
module sprite_palette_lut
    import sprite_pkg::*;
(
    input  logic             frame_Clk,
    input  logic             Reset,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             pix_valid,
    output logic             pix_opaque,
    output logic [RGB_W-1:0] pix_rgb
);

    logic             valid_q, valid_d;
    logic             opaque_q, opaque_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;

    always_comb begin
        valid_d  = in_valid;
        opaque_d = in_valid && (in_idx != '0);
        rgb_d    = opaque_d ? PALETTE[in_idx] : '0;
    end

    always_ff @(posedge frame_Clk) begin
        if (Reset) begin
            valid_q  <= 1'b0;
            opaque_q <= 1'b0;
            rgb_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            opaque_q <= opaque_d;
            rgb_q    <= rgb_d;
        end
    end

    assign pix_valid  = valid_q;
    assign pix_opaque = opaque_q;
    assign pix_rgb    = rgb_q;

endmodule

// File: rtl/sprite_pixel_server.sv
// Sprite ROM responder: request register, one-word hit filter, fixed-latency
// delay line, return word select and palette output stage.
module sprite_pixel_server
    import sprite_pkg::*;
#(
    parameter int                       MEM_LATENCY   = 2,
    parameter logic [SPRITE_ADDR_W-1:0] SPRITE_PIXELS = 21'd4624
) (
    input  logic                     frame_Clk,
    input  logic                     Reset,
    input  logic                     req_valid,
    input  logic [SPRITE_ADDR_W-1:0] req_addr,
    output logic                     mem_rd_en,
    output logic [WADDR_W-1:0]       mem_addr,
    input  logic [WORD_W-1:0]        mem_rdata,
    output logic                     pix_valid,
    output logic                     pix_opaque,
    output logic [RGB_W-1:0]         pix_rgb,
    output logic                     addr_err,
    output logic [15:0]              rd_count,
    output logic [15:0]              hit_count
);

    logic               req_in_range, req_hit, req_rd;
    logic [WADDR_W-1:0] req_word;

    // Index 0 is stage R; index MEM_LATENCY lines up with mem_rdata.
    pipe_tag_t tag_pipe_q [MEM_LATENCY:0];
    pipe_tag_t tag_pipe_d [MEM_LATENCY:0];
    pipe_tag_t ret_tag;

    logic               mem_rd_en_q, mem_rd_en_d;
    logic [WADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WADDR_W-1:0] last_word_q, last_word_d;
    logic               hold_valid_q, hold_valid_d;
    logic [WORD_W-1:0]  hold_word_q, hold_word_d;
    logic [WORD_W-1:0]  ret_word;
    logic               ret_valid_q, ret_valid_d;
    logic [IDX_W-1:0]   ret_idx_q, ret_idx_d;
    logic               addr_err_q, addr_err_d;
    logic [15:0]        rd_count_q, rd_count_d;
    logic [15:0]        hit_count_q, hit_count_d;

    always_comb begin
        req_in_range = req_addr < SPRITE_PIXELS;
        req_word     = req_addr[SPRITE_ADDR_W-1:2];
        req_hit      = hold_valid_q && (req_word == last_word_q) && req_in_range;
        req_rd       = req_valid && req_in_range && !req_hit;

        tag_pipe_d    = tag_pipe_q;
        tag_pipe_d[0] = '{valid: req_valid, hit: req_hit, in_range: req_in_range,
                          nibble: req_addr[1:0]};
        for (int i = 1; i <= MEM_LATENCY; i++)
            tag_pipe_d[i] = tag_pipe_q[i-1];

        mem_rd_en_d  = req_rd;
        mem_addr_d   = req_rd ? req_word : mem_addr_q;
        last_word_d  = last_word_q;
        hold_valid_d = hold_valid_q;
        if (req_valid && req_in_range) begin
            last_word_d  = req_word;
            hold_valid_d = 1'b1;
        end

        // Responses return in order, so a hit always finds its word already held.
        ret_tag     = tag_pipe_q[MEM_LATENCY];
        ret_word    = ret_tag.hit ? hold_word_q : mem_rdata;
        hold_word_d = (ret_tag.valid && ret_tag.in_range && !ret_tag.hit) ? mem_rdata : hold_word_q;
        ret_valid_d = ret_tag.valid;
        ret_idx_d   = ret_tag.in_range ? ret_word[{ret_tag.nibble, 2'b00} +: IDX_W] : '0;

        addr_err_d  = addr_err_q || (req_valid && !req_in_range);
        rd_count_d  = (req_rd && rd_count_q != '1) ? rd_count_q + 16'd1 : rd_count_q;
        hit_count_d = (req_valid && req_hit && hit_count_q != '1) ? hit_count_q + 16'd1 : hit_count_q;
    end

    always_ff @(posedge frame_Clk) begin
        if (Reset) begin
            tag_pipe_q   <= '{default: '0};
            mem_rd_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            last_word_q  <= '0;
            hold_valid_q <= 1'b0;
            hold_word_q  <= '0;
            ret_valid_q  <= 1'b0;
            ret_idx_q    <= '0;
            addr_err_q   <= 1'b0;
            rd_count_q   <= '0;
            hit_count_q  <= '0;
        end else begin
            tag_pipe_q   <= tag_pipe_d;
            mem_rd_en_q  <= mem_rd_en_d;
            mem_addr_q   <= mem_addr_d;
            last_word_q  <= last_word_d;
            hold_valid_q <= hold_valid_d;
            hold_word_q  <= hold_word_d;
            ret_valid_q  <= ret_valid_d;
            ret_idx_q    <= ret_idx_d;
            addr_err_q   <= addr_err_d;
            rd_count_q   <= rd_count_d;
            hit_count_q  <= hit_count_d;
        end
    end

    sprite_palette_lut u_lut (
        .frame_Clk  (frame_Clk),
        .Reset      (Reset),
        .in_valid   (ret_valid_q),
        .in_idx     (ret_idx_q),
        .pix_valid  (pix_valid),
        .pix_opaque (pix_opaque),
        .pix_rgb    (pix_rgb)
    );

    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign addr_err  = addr_err_q;
    assign rd_count  = rd_count_q;
    assign hit_count = hit_count_q;

endmodule

// File: tb/tb_sprite_pixel_server.sv
// Directed bench: MEM_LATENCY=2 and MEM_LATENCY=3 instances share one request stream.
module tb_sprite_pixel_server;

    logic        frame_Clk = 1'b0;
    logic        Reset;
    logic        req_valid;
    logic [20:0] req_addr;

    logic        m2_rd, m3_rd;
    logic [18:0] m2_addr, m3_addr;
    logic [15:0] m2_rdata, m3_rdata;
    logic        p2_valid, p2_opaque, p3_valid, p3_opaque;
    logic [23:0] p2_rgb, p3_rgb;
    logic        err2, err3;
    logic [15:0] rd2, hit2, rd3, hit3;

    logic [15:0] mem [0:7];
    logic [15:0] dp2 [1:2];
    logic [15:0] dp3 [1:3];

    typedef struct { logic v; logic o; logic [23:0] rgb; } exp_t;
    exp_t exq [0:5];

    int n_vec = 0;
    int n_bad = 0;

    always #5 frame_Clk = ~frame_Clk;

    sprite_pixel_server #(.MEM_LATENCY(2)) u_dut (
        .frame_Clk(frame_Clk), .Reset(Reset), .req_valid(req_valid), .req_addr(req_addr),
        .mem_rd_en(m2_rd), .mem_addr(m2_addr), .mem_rdata(m2_rdata),
        .pix_valid(p2_valid), .pix_opaque(p2_opaque), .pix_rgb(p2_rgb),
        .addr_err(err2), .rd_count(rd2), .hit_count(hit2));

    sprite_pixel_server #(.MEM_LATENCY(3)) u_dut3 (
        .frame_Clk(frame_Clk), .Reset(Reset), .req_valid(req_valid), .req_addr(req_addr),
        .mem_rd_en(m3_rd), .mem_addr(m3_addr), .mem_rdata(m3_rdata),
        .pix_valid(p3_valid), .pix_opaque(p3_opaque), .pix_rgb(p3_rgb),
        .addr_err(err3), .rd_count(rd3), .hit_count(hit3));

    // Memory models: data only for real strobes, junk otherwise so stray use shows up.
    always @(posedge frame_Clk) begin
        dp2[1] <= m2_rd ? mem[m2_addr[2:0]] : 16'hDEAD;
        dp2[2] <= dp2[1];
        dp3[1] <= m3_rd ? mem[m3_addr[2:0]] : 16'hDEAD;
        dp3[2] <= dp3[1];
        dp3[3] <= dp3[2];
    end
    assign m2_rdata = dp2[2];
    assign m3_rdata = dp3[3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request cycle; expected pixel given here appears 4 (L=2) / 5 (L=3) calls later.
    task automatic apply(input logic v, input logic [20:0] a,
                         input logic ev, input logic eo, input logic [23:0] er);
        req_valid = v;
        req_addr  = a;
        for (int i = 5; i > 0; i--) exq[i] = exq[i-1];
        exq[0] = '{ev, eo, er};
        @(negedge frame_Clk);
        chk("l2_valid",  {31'd0, p2_valid},  {31'd0, exq[4].v});
        chk("l2_opaque", {31'd0, p2_opaque}, {31'd0, exq[4].o});
        chk("l2_rgb",    {8'd0, p2_rgb},     {8'd0, exq[4].rgb});
        chk("l3_valid",  {31'd0, p3_valid},  {31'd0, exq[5].v});
        chk("l3_opaque", {31'd0, p3_opaque}, {31'd0, exq[5].o});
        chk("l3_rgb",    {8'd0, p3_rgb},     {8'd0, exq[5].rgb});
        req_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, 21'd0, 1'b0, 1'b0, 24'h0);
    endtask

    initial begin
        for (int i = 0; i < 6; i++) exq[i] = '{1'b0, 1'b0, 24'h0};
        for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
        mem[0] = 16'h4321;
        mem[1] = 16'h0005;
        mem[2] = 16'h00A0;
        mem[3] = 16'h7000;   // word 1155, last in-range word
        Reset = 1'b1; req_valid = 1'b0; req_addr = '0;
        @(negedge frame_Clk);
        @(negedge frame_Clk);
        chk("rst_rd_en",  {31'd0, m2_rd}, 32'd0);
        chk("rst_addr",   {13'd0, m2_addr}, 32'd0);
        chk("rst_pvalid", {31'd0, p2_valid}, 32'd0);
        chk("rst_opaque", {31'd0, p2_opaque}, 32'd0);
        chk("rst_rgb",    {8'd0, p2_rgb}, 32'd0);
        chk("rst_err",    {31'd0, err2}, 32'd0);
        chk("rst_rdcnt",  {16'd0, rd2}, 32'd0);
        chk("rst_hitcnt", {16'd0, hit2}, 32'd0);
        Reset = 1'b0;

        // Four pixels of one word: one read, three hits.
        apply(1'b1, 21'd0, 1'b1, 1'b1, 24'hFF0000);
        chk("t1_rd_en", {31'd0, m2_rd}, 32'd1);
        chk("t1_addr",  {13'd0, m2_addr}, 32'd0);
        apply(1'b1, 21'd1, 1'b1, 1'b1, 24'h00FF00);
        chk("t1_hit_no_rd", {31'd0, m2_rd}, 32'd0);
        apply(1'b1, 21'd2, 1'b1, 1'b1, 24'h0000FF);
        apply(1'b1, 21'd3, 1'b1, 1'b1, 24'hFFFF00);
        drain(5);
        chk("t1_rdcnt",  {16'd0, rd2}, 32'd1);
        chk("t1_hitcnt", {16'd0, hit2}, 32'd3);

        // Opaque pixel, then transparent index 0.
        apply(1'b1, 21'd4, 1'b1, 1'b1, 24'hFF00FF);
        chk("t2_addr4", {13'd0, m2_addr}, 32'd1);
        apply(1'b1, 21'd8, 1'b1, 1'b0, 24'h000000);
        chk("t2_rd_en8", {31'd0, m2_rd}, 32'd1);
        chk("t2_addr8",  {13'd0, m2_addr}, 32'd2);
        drain(5);
        chk("t2_rdcnt", {16'd0, rd2}, 32'd3);

        // Range boundary: 4623 is the last valid pixel, 4624 the first invalid.
        apply(1'b1, 21'd4623, 1'b1, 1'b1, 24'hFFFFFF);
        chk("t3_addr4623", {13'd0, m2_addr}, 32'd1155);
        chk("t3_err_clr",  {31'd0, err2}, 32'd0);
        apply(1'b1, 21'd4624, 1'b1, 1'b0, 24'h000000);
        chk("t3_oor_no_rd", {31'd0, m2_rd}, 32'd0);
        chk("t3_addr_hold", {13'd0, m2_addr}, 32'd1155);
        chk("t3_err_set",   {31'd0, err2}, 32'd1);
        drain(5);
        chk("t3_err_sticky", {31'd0, err2}, 32'd1);
        chk("t3_rdcnt",      {16'd0, rd2}, 32'd4);

        // Alternating words: every request is a miss.
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) apply(1'b1, 21'd0, 1'b1, 1'b1, 24'hFF0000);
            else            apply(1'b1, 21'd4, 1'b1, 1'b1, 24'hFF00FF);
        end
        drain(5);
        chk("t4_rdcnt",  {16'd0, rd2}, 32'd24);
        chk("t4_hitcnt", {16'd0, hit2}, 32'd3);
        chk("t4_l3_rdcnt", {16'd0, rd3}, 32'd24);

        // Reset with three requests in flight: none of them may surface.
        apply(1'b1, 21'd0, 1'b0, 1'b0, 24'h0);
        apply(1'b1, 21'd4, 1'b0, 1'b0, 24'h0);
        apply(1'b1, 21'd8, 1'b0, 1'b0, 24'h0);
        Reset = 1'b1;
        apply(1'b0, 21'd0, 1'b0, 1'b0, 24'h0);
        Reset = 1'b0;
        chk("t5_rdcnt",  {16'd0, rd2}, 32'd0);
        chk("t5_hitcnt", {16'd0, hit2}, 32'd0);
        chk("t5_err",    {31'd0, err2}, 32'd0);
        drain(2);
        // Hold register was invalidated, so word 0 must be re-read.
        apply(1'b1, 21'd1, 1'b1, 1'b1, 24'h00FF00);
        chk("t5_reread", {31'd0, m2_rd}, 32'd1);
        drain(5);

        // Read counter saturation.
        force u_dut.rd_count_q = 16'hFFFD;
        drain(1);
        release u_dut.rd_count_q;
        apply(1'b1, 21'd4, 1'b1, 1'b1, 24'hFF00FF);
        chk("t6_rdcnt_inc", {16'd0, rd2}, 32'h0000FFFE);
        apply(1'b1, 21'd0, 1'b1, 1'b1, 24'hFF0000);
        apply(1'b1, 21'd4, 1'b1, 1'b1, 24'hFF00FF);
        apply(1'b1, 21'd0, 1'b1, 1'b1, 24'hFF0000);
        apply(1'b1, 21'd4, 1'b1, 1'b1, 24'hFF00FF);
        chk("t6_rdcnt_sat", {16'd0, rd2}, 32'h0000FFFF);
        drain(5);
        chk("t6_rdcnt_hold", {16'd0, rd2}, 32'h0000FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
